// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode enum, command/response records
// and the default datapath geometry.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_NREGS  = 4;
  localparam int ALU_REG_AW = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                  imm;
    alu_op_e               op;
    logic [ALU_REG_AW-1:0] rd;
    logic [ALU_REG_AW-1:0] rs;
    logic [ALU_REG_AW-1:0] rt;
    logic [ALU_DATA_W-1:0] data;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_REG_AW-1:0] rd;
    logic [ALU_DATA_W-1:0] result;
    logic                  carry;
    logic                  zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write port,
// synchronous clear.
module alu_regfile #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ra_a_i,
  output logic [DATA_W-1:0] rd_a_o,
  input  logic [REG_AW-1:0] ra_b_i,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  assign rd_a_o = regs_q[ra_a_i];
  assign rd_b_o = regs_q[ra_b_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues register-based commands to an external combinational ALU, writes the result
// back to the register file and returns it on a response channel.
//
// state  | meaning
// IDLE   | ready for a command; operands sampled from the regfile on accept
// EXEC   | alu_* stable; result (or immediate) captured and written back
// RESP   | response held until rsp_ready
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREGS  = ALU_NREGS,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_imm,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_AW-1:0] rsp_rd,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              imm_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  alu_op_e           alu_sel_q;
  logic [REG_AW-1:0] rsp_rd_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_carry_q, rsp_zero_q;

  logic [DATA_W-1:0] rs_data, rt_data, wb_data_d;
  logic              accept, wb_en;

  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign wb_en     = (state_q == S_EXEC);
  assign wb_data_d = imm_q ? data_q : alu_result;

  // Reset takes priority inside the regfile, so a command caught in EXEC never writes back.
  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_regfile (
    .clk_i  (clk),
    .rst_i  (rst),
    .ra_a_i (cmd_rs),
    .rd_a_o (rs_data),
    .ra_b_i (cmd_rt),
    .rd_b_o (rt_data),
    .we_i   (wb_en),
    .wa_i   (rd_q),
    .wd_i   (wb_data_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      imm_q        <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= ALU_ADD;
      rsp_rd_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        imm_q  <= cmd_imm;
        rd_q   <= cmd_rd;
        data_q <= cmd_data;
        // Immediates leave the ALU operands untouched so the ALU inputs never toggle needlessly.
        if (!cmd_imm) begin
          alu_a_q   <= rs_data;
          alu_b_q   <= rt_data;
          alu_sel_q <= alu_op_e'(cmd_op);
        end
      end
      if (wb_en) begin
        rsp_rd_q     <= rd_q;
        rsp_result_q <= wb_data_d;
        rsp_carry_q  <= !imm_q && alu_carry;
        rsp_zero_q   <= imm_q ? (data_q == '0) : alu_zero;
      end
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_rd     = rsp_rd_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed-vector bench for alu_cmd_sequencer with a behavioural 4-bit ALU behind alu_*.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_imm;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt;
  logic [3:0] cmd_data;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carry, alu_zero;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_rd;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_zero;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_imm(cmd_imm), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: 5-bit intermediate, bit 4 is carry/borrow/shift-out.
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} - {1'b0, b};
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, a ^ b};
      3'd5:    s = {1'b0, ~a};
      3'd6:    s = {a, 1'b0};
      default: s = {a[0], 1'b0, a[3:1]};
    endcase
    return {s[4], (s[3:0] == 4'd0), s[3:0]};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_sel);

  typedef struct {
    logic       imm;
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic [3:0] data;
    logic [3:0] res;
    logic       c, z;
  } vec_t;

  vec_t       vt [14];
  int         n_chk = 0, n_fail = 0;
  logic [3:0] mdl [4];
  logic [3:0] exp_a, exp_b;
  logic [2:0] exp_sel;
  alu_rsp_t   q [$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready timeout"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic drive(input logic imm, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input logic [3:0] data);
    cmd_imm = imm; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_data = data;
    cmd_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.imm, v.op, v.rd, v.rs, v.rt, v.data);
    rsp_ready = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    if (!v.imm) begin
      exp_a = mdl[v.rs]; exp_b = mdl[v.rt]; exp_sel = v.op;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " exec cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " alu_a"}, 32'(alu_a), 32'(exp_a));
    chk({tag, " alu_b"}, 32'(alu_b), 32'(exp_b));
    chk({tag, " alu_sel"}, 32'(alu_sel), 32'(exp_sel));
    @(negedge clk);
    chk({tag, " rsp_valid latency"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_rd"}, 32'(rsp_rd), 32'(v.rd));
    chk({tag, " rsp_result"}, 32'(rsp_result), 32'(v.res));
    chk({tag, " rsp_carry"}, 32'(rsp_carry), 32'(v.c));
    chk({tag, " rsp_zero"}, 32'(rsp_zero), 32'(v.z));
    mdl[v.rd] = v.res;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          imm   op    rd    rs    rt    data   res    c     z
    vt[0]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9,  4'd9,  1'b0, 1'b0};
    vt[1]  = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd8,  4'd8,  1'b0, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0,  4'd1,  1'b1, 1'b0};
    vt[3]  = '{1'b0, 3'd1, 2'd3, 2'd1, 2'd0, 4'd0,  4'd15, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 3'd4, 2'd0, 2'd0, 2'd0, 4'd0,  4'd0,  1'b0, 1'b1};
    vt[5]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9,  4'd9,  1'b0, 1'b0};
    vt[6]  = '{1'b0, 3'd6, 2'd1, 2'd0, 2'd0, 4'd0,  4'd2,  1'b1, 1'b0};
    vt[7]  = '{1'b0, 3'd0, 2'd3, 2'd1, 2'd1, 4'd0,  4'd4,  1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'd2, 2'd2, 2'd3, 2'd0, 4'd0,  4'd0,  1'b0, 1'b1};
    vt[9]  = '{1'b0, 3'd3, 2'd2, 2'd3, 2'd0, 4'd0,  4'd13, 1'b0, 1'b0};
    vt[10] = '{1'b0, 3'd5, 2'd0, 2'd0, 2'd0, 4'd0,  4'd6,  1'b0, 1'b0};
    vt[11] = '{1'b0, 3'd7, 2'd1, 2'd2, 2'd0, 4'd0,  4'd6,  1'b1, 1'b0};
    vt[12] = '{1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd0,  4'd0,  1'b0, 1'b1};
    vt[13] = '{1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0,  4'd12, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 4'd0;
    exp_a = 4'd0; exp_b = 4'd0; exp_sel = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_result", 32'(rsp_result), 32'd0);
    chk("reset rsp_rd", 32'(rsp_rd), 32'd0);
    chk("reset rsp_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
    chk("reset alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Backpressure: R0=12, R1=6 -> ADD rd2 = 2 with carry; an ignored imm to R3 meanwhile.
    @(negedge clk);
    drive(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0);
    rsp_ready = 1'b0;
    wait_ready("bp");
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp hold cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp hold rsp", 32'({rsp_rd, rsp_result, rsp_carry, rsp_zero}), 32'({2'd2, 4'd2, 1'b1, 1'b0}));
      if (k == 1) drive(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd5);
      if (k == 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp release cmd_ready", 32'(cmd_ready), 32'd1);
    mdl[2] = 4'd2;
    v = '{1'b0, 3'd0, 2'd0, 2'd3, 2'd2, 4'd0, 4'd2, 1'b0, 1'b0};
    run_vec(v, "bp after");

    // Reset while an ADD rd2 sits in EXEC.
    @(negedge clk);
    drive(1'b0, 3'd0, 2'd2, 2'd0, 2'd0, 4'd0);
    wait_ready("rst");
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    for (int i = 0; i < 4; i++) mdl[i] = 4'd0;
    exp_a = 4'd0; exp_b = 4'd0; exp_sel = 3'd0;
    v = '{1'b0, 3'd0, 2'd1, 2'd2, 2'd2, 4'd0, 4'd0, 1'b0, 1'b1};
    run_vec(v, "rst after");

    // Back-to-back random commands with rsp_ready held high.
    rsp_ready = 1'b1;
    @(negedge clk);
    fork
      begin
        int last = 0;
        for (int i = 0; i < 20; i++) begin
          alu_rsp_t e;
          logic [5:0] r;
          drive(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
          wait_ready("b2b");
          if (i > 0) chk("b2b accept spacing", 32'(cyc - last), 32'd3);
          last = cyc;
          @(posedge clk);
          e.rd = cmd_rd;
          if (cmd_imm) begin
            e.result = cmd_data; e.carry = 1'b0; e.zero = (cmd_data == 4'd0);
          end else begin
            r = alu_f(mdl[cmd_rs], mdl[cmd_rt], cmd_op);
            e.result = r[3:0]; e.carry = r[5]; e.zero = r[4];
          end
          mdl[e.rd] = e.result;
          q.push_back(e);
          @(negedge clk);
        end
        cmd_valid = 1'b0;
      end
      begin
        int got = 0;
        alu_rsp_t e;
        for (int c = 0; c < 90; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            got++;
            if (q.size() == 0) chk("b2b unexpected response", 32'd1, 32'd0);
            else begin
              e = q.pop_front();
              chk("b2b rsp", 32'({rsp_rd, rsp_result, rsp_carry, rsp_zero}),
                  32'({e.rd, e.result, e.carry, e.zero}));
            end
          end
        end
        chk("b2b response count", 32'(got), 32'd20);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
